// File: rtl/mem_port_arbiter_if.sv
// Bus bundle tying the CPU and DMA requesters, the memory port arbiter and main memory.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter and sequencer for the single-ported main memory; one full access per grant.
// Define ARB_CPU_PRIORITY_EN for fixed CPU priority; otherwise ties are resolved round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic any_req;
    logic pick_dma;

    assign any_req = bus.cpu_req | bus.dma_req;

`ifdef ARB_CPU_PRIORITY_EN
    // DMA only wins IDLE edges that the CPU leaves empty.
    assign pick_dma = ~bus.cpu_req;
`else
    logic last_grant_q, last_grant_d;

    // On a tie the port that did not win last time goes next.
    assign pick_dma = bus.dma_req & (~bus.cpu_req | ~last_grant_q);

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && any_req) begin
            last_grant_d = pick_dma;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_comb begin
        // NOTE: every next-state value is defaulted first so no branch can infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = ISSUE;
                    owner_d     = pick_dma;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_dma ? bus.dma_we    : bus.cpu_we;
                    mem_addr_d  = pick_dma ? bus.dma_addr  : bus.cpu_addr;
                    mem_wdata_d = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    state_d   = DONE;
                    cpu_ack_d = ~owner_q;
                    dma_ack_d = owner_q;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d   = DONE;
                    cpu_ack_d = ~owner_q;
                    dma_ack_d = owner_q;
                    if (owner_q) begin
                        dma_rdata_d = bus.mem_rdata;
                    end else begin
                        cpu_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (Reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= 3'd0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case sequences,
// and random traffic against a transaction-timing reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W      = 9;
    localparam int DATA_W      = 32;
    localparam int MEM_LAT     = 3;
    localparam int MEM_WORDS   = 1 << ADDR_W;
    localparam int RAND_CYCLES = 600;

    typedef struct {
        bit                port;   // 0 = CPU, 1 = DMA
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                lat;    // cycles from driving req to the end of the ack cycle
        logic [DATA_W-1:0] cpu_rd;
        logic [DATA_W-1:0] dma_rd;
    } vec_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    vec_t vecs [10];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    // Memory: read data is valid only during the single cycle MEM_LAT edges after the strobe.
    logic [DATA_W-1:0] env_mem [0:MEM_WORDS-1] = '{default: '0};
    logic [DATA_W-1:0] rd_hold = '0;
    int                rd_cnt  = 0;

    always @(posedge Clock) begin
        if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                env_mem[bus.mem_addr] <= bus.mem_wdata;
            end else begin
                rd_hold <= env_mem[bus.mem_addr];
                rd_cnt  <= MEM_LAT;
            end
        end
    end

    assign bus.mem_rdata = (rd_cnt == 1) ? rd_hold : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic ack_of(input bit p);
        return p ? bus.dma_ack : bus.cpu_ack;
    endfunction

    task automatic drive_port(input bit p, input bit req, input bit we,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (!p) begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end else begin
            bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        int    n;
        bit    seen;
        tag = $sformatf("vec%0d", idx);
        drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        @(negedge Clock);
        check({tag, " mem_en"},   32'(bus.mem_en), 1);
        check({tag, " mem_we"},   32'(bus.mem_we), 32'(v.we));
        check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(v.addr));
        if (v.we) check({tag, " mem_wdata"}, bus.mem_wdata, v.wdata);
        check({tag, " busy"},     32'(bus.busy), 1);
        check({tag, " owner"},    32'(bus.owner), 32'(v.port));
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge Clock);
            n++;
            check({tag, " single strobe"}, 32'(bus.mem_en), 0);
            check({tag, " other ack"},     32'(ack_of(!v.port)), 0);
            seen = ack_of(v.port);
        end
        check({tag, " latency"},   32'(n), 32'(v.lat));
        drive_port(v.port, 1'b0, 1'b0, '0, '0);
        check({tag, " cpu_rdata"}, bus.cpu_rdata, v.cpu_rd);
        check({tag, " dma_rdata"}, bus.dma_rdata, v.dma_rd);
        @(negedge Clock);
        check({tag, " busy falls"}, 32'(bus.busy), 0);
        check({tag, " ack pulse"},  32'(ack_of(v.port)), 0);
    endtask

    task automatic run_reset_mid();
        drive_port(1'b0, 1'b1, 1'b0, 9'h012, '0);
        @(negedge Clock);
        check("rst-mid issue", 32'(bus.mem_en), 1);
        @(negedge Clock);
        check("rst-mid in wait", 32'(bus.busy), 1);
        Reset = 1'b1;
        #1;
        check("rst-mid async busy",  32'(bus.busy), 0);
        check("rst-mid async rdata", bus.cpu_rdata, 32'h0);
        @(negedge Clock);
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            check("rst-mid no ack", 32'(bus.cpu_ack), 0);
            check("rst-mid no strobe", 32'(bus.mem_en), 0);
            check("rst-mid idle", 32'(bus.busy), 0);
            check("rst-mid rdata", bus.cpu_rdata, 32'h0);
        end
    endtask

    task automatic run_seq_both();
        logic exp_own [4];
        logic got_own [4];
        int   got_cyc [4];
        int   g   = 0;
        int   cyc = 0;
`ifdef ARB_CPU_PRIORITY_EN
        exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        got_own = '{default: 1'bx};
        got_cyc = '{default: -100};
        do_reset();
        drive_port(1'b0, 1'b1, 1'b1, 9'h010, 32'hC0C0_0001);
        drive_port(1'b1, 1'b1, 1'b1, 9'h020, 32'hD0D0_0002);
        while (g < 4 && cyc < 60) begin
            @(negedge Clock);
            cyc++;
            if (bus.mem_en) begin
                got_own[g] = bus.owner;
                got_cyc[g] = cyc;
                g++;
            end
        end
        check("both grant count", 32'(g), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("both owner%0d", i), 32'(got_own[i]), 32'(exp_own[i]));
            if (i > 0) check($sformatf("both spacing%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 3);
        end
        @(negedge Clock);
        check("both last ack", 32'(ack_of(exp_own[3])), 1);
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge Clock);
        check("both idle gap", 32'(bus.mem_en), 0);
        @(negedge Clock);
        check("dma after cpu drop strobe", 32'(bus.mem_en), 1);
        check("dma after cpu drop owner",  32'(bus.owner), 1);
        @(negedge Clock);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge Clock);
    endtask

    task automatic run_cpu_hold();
        int g   = 0;
        int cyc = 0;
        int got_cyc [2];
        logic got_own [2];
        got_own = '{default: 1'bx};
        got_cyc = '{default: -100};
        drive_port(1'b0, 1'b1, 1'b1, 9'h030, 32'h0BAD_F00D);
        while (g < 2 && cyc < 30) begin
            @(negedge Clock);
            cyc++;
            if (bus.mem_en) begin
                got_own[g] = bus.owner;
                got_cyc[g] = cyc;
                g++;
            end
        end
        check("hold grant count", 32'(g), 2);
        check("hold owner0", 32'(got_own[0]), 0);
        check("hold owner1", 32'(got_own[1]), 0);
        check("hold one idle cycle", 32'(got_cyc[1] - got_cyc[0]), 3);
        @(negedge Clock);
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge Clock);
    endtask

    // Reference model: each grant is a timed transaction (grant edge, ack edge, free edge).
    task automatic run_random();
        logic [DATA_W-1:0] model_mem [0:MEM_WORDS-1];
        logic [DATA_W-1:0] exp_rd [2];
        bit                req_v  [2];
        bit                we_v   [2];
        logic [ADDR_W-1:0] addr_v [2];
        logic [DATA_W-1:0] wd_v   [2];
        bit                m_last  = 1'b1;
        int                m_free  = 0;
        int                m_grant = -1;
        int                m_ack   = -1;
        bit                m_own   = 1'b0;
        bit                m_we    = 1'b0;
        logic [ADDR_W-1:0] m_addr  = '0;
        logic [DATA_W-1:0] m_wdata = '0;
        logic [DATA_W-1:0] m_rdval = '0;
        bit                dropped;
        bit                w;
        bit                busy_exp;
        do_reset();
        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = env_mem[i];
        exp_rd = '{default: '0};
        req_v  = '{default: 1'b0};
        we_v   = '{default: 1'b0};
        addr_v = '{default: '0};
        wd_v   = '{default: '0};
        for (int k = 0; k < RAND_CYCLES; k++) begin
            if (k == m_ack && !m_we) exp_rd[m_own] = m_rdval;
            busy_exp = (m_grant >= 0) && (k >= m_grant) && (k <= m_ack);
            check("rand busy",   32'(bus.busy),   32'(busy_exp));
            check("rand mem_en", 32'(bus.mem_en), 32'(k == m_grant));
            if (k == m_grant) begin
                check("rand mem_we",   32'(bus.mem_we),   32'(m_we));
                check("rand mem_addr", 32'(bus.mem_addr), 32'(m_addr));
                if (m_we) check("rand mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (busy_exp) check("rand owner", 32'(bus.owner), 32'(m_own));
            check("rand cpu_ack",   32'(bus.cpu_ack), 32'(k == m_ack && !m_own));
            check("rand dma_ack",   32'(bus.dma_ack), 32'(k == m_ack && m_own));
            check("rand cpu_rdata", bus.cpu_rdata, exp_rd[0]);
            check("rand dma_rdata", bus.dma_rdata, exp_rd[1]);

            for (int p = 0; p < 2; p++) begin
                dropped = 1'b0;
                if (req_v[p] && ack_of(p[0])) begin
                    req_v[p] = 1'b0;
                    dropped  = 1'b1;
                end
                if (!req_v[p] && !dropped && $urandom_range(0, 2) == 0) begin
                    req_v[p]  = 1'b1;
                    we_v[p]   = 1'($urandom_range(0, 1));
                    addr_v[p] = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
                    wd_v[p]   = $urandom;
                end
                drive_port(p[0], req_v[p], we_v[p], addr_v[p], wd_v[p]);
            end

            if (k + 1 >= m_free && (req_v[0] || req_v[1])) begin
`ifdef ARB_CPU_PRIORITY_EN
                w = !req_v[0];
`else
                w = (req_v[0] && req_v[1]) ? !m_last : req_v[1];
`endif
                m_last  = w;
                m_own   = w;
                m_we    = we_v[w];
                m_addr  = addr_v[w];
                m_wdata = wd_v[w];
                m_grant = k + 1;
                if (m_we) begin
                    model_mem[m_addr] = m_wdata;
                    m_ack = k + 2;
                end else begin
                    m_rdval = model_mem[m_addr];
                    m_ack   = k + 2 + MEM_LAT;
                end
                m_free = m_ack + 2;
            end
            @(negedge Clock);
        end
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (8) @(negedge Clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 9'h012, 32'hDEAD_BEEF, 2,           32'h0,         32'h0};
        vecs[1] = '{1'b1, 1'b1, 9'h045, 32'h00C0_FFEE, 2,           32'h0,         32'h0};
        vecs[2] = '{1'b1, 1'b0, 9'h045, 32'h0,         2 + MEM_LAT, 32'h0,         32'h00C0_FFEE};
        vecs[3] = '{1'b0, 1'b0, 9'h012, 32'h0,         2 + MEM_LAT, 32'hDEAD_BEEF, 32'h00C0_FFEE};
        vecs[4] = '{1'b0, 1'b1, 9'h1FF, 32'hFFFF_FFFF, 2,           32'hDEAD_BEEF, 32'h00C0_FFEE};
        vecs[5] = '{1'b1, 1'b0, 9'h1FF, 32'h0,         2 + MEM_LAT, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
        vecs[6] = '{1'b0, 1'b0, 9'h000, 32'h0,         2 + MEM_LAT, 32'h0,         32'hFFFF_FFFF};
        vecs[7] = '{1'b1, 1'b1, 9'h000, 32'h1234_5678, 2,           32'h0,         32'hFFFF_FFFF};
        vecs[8] = '{1'b1, 1'b0, 9'h000, 32'h0,         2 + MEM_LAT, 32'h0,         32'h1234_5678};
        vecs[9] = '{1'b0, 1'b0, 9'h045, 32'h0,         2 + MEM_LAT, 32'h00C0_FFEE, 32'h1234_5678};

        do_reset();
        check("reset busy",      32'(bus.busy), 0);
        check("reset owner",     32'(bus.owner), 0);
        check("reset mem_en",    32'(bus.mem_en), 0);
        check("reset mem_we",    32'(bus.mem_we), 0);
        check("reset mem_addr",  32'(bus.mem_addr), 0);
        check("reset mem_wdata", bus.mem_wdata, 32'h0);
        check("reset cpu_ack",   32'(bus.cpu_ack), 0);
        check("reset dma_ack",   32'(bus.dma_ack), 0);
        check("reset cpu_rdata", bus.cpu_rdata, 32'h0);
        check("reset dma_rdata", bus.dma_rdata, 32'h0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        run_reset_mid();
        run_seq_both();
        run_cpu_hold();
        run_random();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer for the single-ported main memory of the RISC datapath. Shares the memory between the CPU side (driven by `control_unit` through MAR/MDR) and a DMA/IO requester. Each grant runs one complete read or write, with a fixed memory latency. Completion is signalled to the requester with a one-cycle acknowledge.

## Interface
- `ADDR_W`, 9, memory word-address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 1, cycles from the `mem_en` sample edge to valid `mem_rdata`. Legal range is 1..7.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `cpu_req`  in  1  CPU request; held high until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr`  in  ADDR_W  address; stable while `cpu_req` is high.
- `cpu_wdata`  in  DATA_W  write data; stable while `cpu_req` is high.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  registered read data.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ack`, `dma_rdata`: same meanings for the DMA port.
- `mem_en`  out  1  memory access strobe, one cycle per transfer.
- `mem_we`  out  1  memory write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  0 = CPU, 1 = DMA; meaningful while `busy` is high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. State is encoded in 2 bits.
- IDLE:
  - If any `req` is high at the edge, latch the winner's `we`/`addr`/`wdata` into the `mem_*` registers, set `owner`, go to ISSUE.
  - If no `req` is high, stay in IDLE.
- Arbitration (default build): round-robin.
  - `last_grant` flop; a tie goes to the port that is not `last_grant`.
  - `last_grant` updates on every grant.
  - A lone request always wins.
- ISSUE: `mem_en`=1 for exactly one cycle.
  - Write: go to DONE.
  - Read: load the 3-bit latency counter with `MEM_LAT`-1, go to WAIT.
- WAIT: decrement the counter each cycle.
  - When the counter is 0, capture `mem_rdata` into the owner's `rdata` register and go to DONE.
  - WAIT lasts exactly `MEM_LAT` cycles.
- DONE: owner's `ack`=1 for one cycle, then go to IDLE.
- Requester rule: deassert `req` at the edge that ends the `ack` cycle. A `req` still high in IDLE after DONE is a new request.
- `rdata` holds its value until that port's next read completes. Writes do not change `rdata`.
- The non-owner's `req` is ignored until IDLE. It is neither dropped nor acknowledged.
- Reset values:
  - FSM = IDLE.
  - `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` = 0.
  - Both `ack`s = 0; both `rdata` = 0.
  - `busy` = 0; `owner` = 0.
  - `last_grant` = 1 (DMA), so the first tie goes to the CPU.
  - The counter = 0.
- Reset mid-transfer:
  - Aborts to IDLE immediately; no `ack` is issued.
  - A write already strobed in ISSUE may have taken effect.
- All outputs are registered. There is no combinational path from `req` to any `mem_*` signal or `ack`.

## Timing
- `req` first sampled high at edge E0 (state IDLE).
- ISSUE occupies cycle E0→E1.
- Write: `ack` high in cycle E1→E2. Latency is 2 cycles.
- Read: WAIT occupies E1→E(1+`MEM_LAT`); `ack` is high in the following cycle.
  - Latency is 2+`MEM_LAT` cycles; `rdata` is valid in the `ack` cycle.
- Minimum of 1 IDLE cycle between any two transfers.
  - Back-to-back writes: 1 transfer per 3 cycles.
  - Back-to-back reads: 1 transfer per 3+`MEM_LAT` cycles.
- `busy` rises in the ISSUE cycle and falls in the first IDLE cycle after DONE.

## Configuration
- `ARB_CPU_PRIORITY_EN` defined:
  - Fixed priority; the CPU wins every tie.
  - `last_grant` is not implemented.
  - DMA is served only in IDLE cycles where `cpu_req` is low.
- `ARB_CPU_PRIORITY_EN` undefined: round-robin as in Operation.

## Test plan
- Reset, then `cpu_req` write with addr 0x012, data 0xDEADBEEF:
  - `mem_en`=1, `mem_we`=1, `mem_addr`=0x012 in the cycle after the request.
  - `cpu_ack` one cycle later.
  - `busy` falls in the next cycle.
- `MEM_LAT`=3, `dma_req` read at 0x045, memory returns 0x00C0FFEE:
  - `dma_ack` 5 cycles after the request.
  - `dma_rdata`=0x00C0FFEE; `cpu_rdata` stays unchanged.
- Both ports request continuously from reset, round-robin build:
  - Grants alternate CPU, DMA, CPU, DMA; `owner` tracks each grant.
- Same stimulus with `ARB_CPU_PRIORITY_EN` defined and `cpu_req` re-raised each IDLE:
  - DMA is never granted.
  - After `cpu_req` drops, DMA is granted on the next IDLE edge.
- `Reset` asserted during WAIT of a CPU read:
  - FSM returns to IDLE; no `cpu_ack`; `cpu_rdata`=0.
  - `mem_en` stays 0 until a new request.
- `cpu_req` held high across `cpu_ack`:
  - A second CPU transfer starts after exactly one IDLE cycle.
  - In the round-robin build with `dma_req` also high, DMA wins that IDLE instead.
